// File: rtl/reg_operand_fetch.sv
// Operand fetch stage: 2**ADDR_W general registers with a load port, and a one-deep
// valid/ready output register that returns two source operands with write forwarding.
module reg_operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] bank_q [NREGS];
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [ADDR_W-1:0] src_a_q, src_b_q;

    logic [DATA_W-1:0] op_a_d, op_b_d;
    logic              accept;
    logic              hit_a, hit_b;

    assign rd_ready = (state_q == EMPTY) || out_ready;
    assign accept   = rd_req && rd_ready;

    // A write landing on a held source address must reach the stalled operand.
    assign hit_a = load && (wr_addr == src_a_q);
    assign hit_b = load && (wr_addr == src_b_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a path
        // that skips the assignment infers a latch.
        op_a_d = bank_q[rd_addr_a];
        op_b_d = bank_q[rd_addr_b];
        if (load && (wr_addr == rd_addr_a)) begin
            op_a_d = d_in;
        end
        if (load && (wr_addr == rd_addr_b)) begin
            op_b_d = d_in;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: bank_q is a flop array, not a RAM macro, so it is cleared on reset
        // like any other register; a RAM would have to be cleared by a sweep.
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (load) begin
            bank_q[wr_addr] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= EMPTY;
            op_a_q  <= '0;
            op_b_q  <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        op_a_q  <= op_a_d;
                        op_b_q  <= op_b_d;
                        src_a_q <= rd_addr_a;
                        src_b_q <= rd_addr_b;
                    end
                end
                FULL: begin
                    if (accept) begin
                        op_a_q  <= op_a_d;
                        op_b_q  <= op_b_d;
                        src_a_q <= rd_addr_a;
                        src_b_q <= rd_addr_b;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end else begin
                        if (hit_a) begin
                            op_a_q <= d_in;
                        end
                        if (hit_b) begin
                            op_b_q <= d_in;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == FULL);
    assign d_out_a   = op_a_q;
    assign d_out_b   = op_b_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural register-bank / output-slot model.
module tb_reg_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic        rd_req;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic        rd_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;

    int n_tests = 0;
    int n_fail  = 0;

    reg_operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_ready  (rd_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register file array plus one output slot that remembers
    // which registers its operands came from.
    logic [15:0] m_regs [8];
    logic        m_valid = 1'b0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [2:0]  m_sa = '0, m_sb = '0;
    bit          m_live = 1'b0;

    function automatic logic [15:0] read_now(input logic [2:0] a);
        return (load && wr_addr == a) ? d_in : m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_valid = 1'b0;
            m_a = '0; m_b = '0; m_sa = '0; m_sb = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (rd_req && (!m_valid || out_ready)) begin
                m_a = read_now(rd_addr_a);
                m_b = read_now(rd_addr_b);
                m_sa = rd_addr_a;
                m_sb = rd_addr_b;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end else if (m_valid) begin
                if (load && wr_addr == m_sa) m_a = d_in;
                if (load && wr_addr == m_sb) m_b = d_in;
            end
            if (load) m_regs[wr_addr] = d_in;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model out_valid", 32'(out_valid), 32'(m_valid));
            check("model rd_ready", 32'(rd_ready), 32'(!m_valid || out_ready));
            check("model d_out_a", 32'(d_out_a), 32'(m_a));
            check("model d_out_b", 32'(d_out_b), 32'(m_b));
        end
    end

    task automatic drive(input logic ld, input logic [2:0] wa, input logic [15:0] di,
                         input logic rq, input logic [2:0] ra, input logic [2:0] rb,
                         input logic ordy);
        load = ld; wr_addr = wa; d_in = di;
        rd_req = rq; rd_addr_a = ra; rd_addr_b = rb; out_ready = ordy;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
        @(negedge clk); #1;

        // 1. Reset
        cycle();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset d_out_a", 32'(d_out_a), 32'h0000);
        check("reset d_out_b", 32'(d_out_b), 32'h0000);
        check("reset rd_ready", 32'(rd_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(2 * i), 3'(2 * i + 1), 1'b1);
            cycle();
            check("post-reset read a", 32'(d_out_a), 32'h0000);
            check("post-reset read b", 32'(d_out_b), 32'h0000);
            check("post-reset valid", 32'(out_valid), 32'd1);
        end

        // 2. Write then read
        drive(1'b1, 3'd3, 16'hAAAA, 1'b0, 3'd0, 3'd0, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3, 1'b1);
        cycle();
        check("wr-rd valid", 32'(out_valid), 32'd1);
        check("wr-rd a", 32'(d_out_a), 32'hAAAA);
        check("wr-rd b", 32'(d_out_b), 32'hAAAA);
        drive(1'b0, 3'd3, 16'hBBBB, 1'b1, 3'd3, 3'd3, 1'b1);
        cycle();
        check("no-load keep a", 32'(d_out_a), 32'hAAAA);
        check("no-load keep b", 32'(d_out_b), 32'hAAAA);

        // 3. Forwarding
        drive(1'b1, 3'd2, 16'h00FF, 1'b0, 3'd0, 3'd0, 1'b1);
        cycle();
        drive(1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd2, 1'b1);
        cycle();
        check("fwd a", 32'(d_out_a), 32'h1234);
        check("fwd b", 32'(d_out_b), 32'h00FF);

        // 4. Stall
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 1'b0);
        #1;
        check("stall rd_ready", 32'(rd_ready), 32'd0);
        cycle();
        check("stall valid", 32'(out_valid), 32'd1);
        check("stall hold a", 32'(d_out_a), 32'h1234);
        check("stall hold b", 32'(d_out_b), 32'h00FF);
        drive(1'b1, 3'd2, 16'hBEEF, 1'b1, 3'd0, 3'd0, 1'b0);
        cycle();
        check("stall track b", 32'(d_out_b), 32'hBEEF);
        check("stall track a", 32'(d_out_a), 32'h1234);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
        cycle();
        check("handoff valid", 32'(out_valid), 32'd0);
        check("handoff keep b", 32'(d_out_b), 32'hBEEF);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd5, 1'b1);
        cycle();
        check("after stall a", 32'(d_out_a), 32'hBEEF);
        check("after stall b", 32'(d_out_b), 32'h1234);

        // 5. Throughput
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'(16'hC000 + i * 16'h0111), 1'b0, 3'd0, 3'd0, 1'b1);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(2 * i), 3'(2 * i + 1), 1'b1);
            cycle();
            check("burst valid", 32'(out_valid), 32'd1);
            check("burst a", 32'(d_out_a), 32'(16'hC000 + (2 * i) * 16'h0111));
            check("burst b", 32'(d_out_b), 32'(16'hC000 + (2 * i + 1) * 16'h0111));
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
        cycle();
        check("burst drain", 32'(out_valid), 32'd0);

        // 6. Reset mid-stall with a concurrent load
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd7, 1'b1);
        cycle();
        check("pre-rst a", 32'(d_out_a), 32'hC777);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
        cycle();
        check("pre-rst stall", 32'(out_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 3'd7, 1'b0);
        cycle();
        check("mid-stall rst valid", 32'(out_valid), 32'd0);
        check("mid-stall rst a", 32'(d_out_a), 32'h0000);
        check("mid-stall rst rd_ready", 32'(rd_ready), 32'd1);
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd0, 1'b1);
        cycle();
        check("rst blocks load a", 32'(d_out_a), 32'h0000);
        check("rst blocks load b", 32'(d_out_b), 32'h0000);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 6));
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
